usb_tx_nrzi_encoder: RTL and testbench

//  Full-speed USB transmit line encoder. Sits directly downstream of bit_stuffer.
//  - Paces the serial stream at one bit per CLKS_PER_BIT clocks.
//  - Inserts a stuffed 0 whenever the stuffer raises pause.
//  - NRZI-encodes onto dplus/dminus.
//  - On request, appends the EOP sequence: SE0, SE0, J.

---
 rtl/usb_tx_pkg.sv | 54 +++++
 rtl/usb_bit_timer.sv | 46 ++++
 rtl/usb_tx_nrzi_encoder.sv | 130 +++++++++++++
 tb/tb_usb_tx_nrzi_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
//   Shared definitions for the USB full-speed transmit line path.
//   - line_state_t   : abstract bus state (J, K, SE0)
//   - tx_enc_state_t : transmit encoder FSM states
//   - LINE_*         : {dplus, dminus} drive encodings
//   - line_encode    : abstract line state -> {dplus, dminus}
//   - nrzi_next      : next line state for one NRZI-encoded data bit
// -----------------------------------------------------------------------------
package usb_tx_pkg;

    typedef enum logic [1:0] {
        J   = 2'd0,
        K   = 2'd1,
        SE0 = 2'd2
    } line_state_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DATA      = 3'd1,
        ST_EOP_SE0_A = 3'd2,
        ST_EOP_SE0_B = 3'd3,
        ST_EOP_J     = 3'd4
    } tx_enc_state_t;

    // {dplus, dminus}; (1,1) is deliberately absent.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [1:0] line_encode(input line_state_t ls);
        logic [1:0] enc;
        case (ls)
            J:       enc = LINE_J;
            K:       enc = LINE_K;
            SE0:     enc = LINE_SE0;
            default: enc = LINE_J;
        endcase
        return enc;
    endfunction

    // A 0 toggles between J and K, a 1 holds. SE0 is never the current
    // state while data is being encoded, so it falls back to J.
    function automatic line_state_t nrzi_next(input line_state_t cur, input logic b);
        line_state_t nxt;
        if (b) begin
            nxt = cur;
        end else begin
            nxt = (cur == J) ? K : J;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// -----------------------------------------------------------------------------
// usb_bit_timer
//   Modulo-CLKS_PER_BIT counter that marks USB bit boundaries. Shared by the
//   TX encoder and the RX path.
//
// Ports
//   clk     in  system clock
//   rst     in  asynchronous active-high reset (count -> 0)
//   clear   in  synchronous clear of the count (higher priority than enable)
//   enable  in  count while high; count holds while low
//   tick    out high in the last clock of each bit time (count == CLKS_PER_BIT-1)
// -----------------------------------------------------------------------------
module usb_bit_timer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/usb_tx_nrzi_encoder.sv
// -----------------------------------------------------------------------------
// usb_tx_nrzi_encoder
//   Full-speed USB transmit line encoder, fed by the bit stuffer. Paces the
//   serial stream at one bit per CLKS_PER_BIT clocks, sends a stuffed 0 when
//   the stuffer raises pause, NRZI-encodes onto D+/D-, and on request closes
//   the packet with EOP (SE0, SE0, J).
//
// Ports
//   clk       in  system clock
//   rst       in  asynchronous active-high reset (line -> J, FSM -> IDLE)
//   tx_start  in  1-cycle pulse, starts a packet; ignored while busy
//   d_bit     in  current serial data bit
//   pause     in  current bit slot carries a stuffed 0
//   eop_req   in  level, request EOP after the last data bit
//   shift_en  out 1-cycle pulse, upstream advances to the next data bit
//   bit_tick  out 1-cycle pulse at every bit boundary while busy
//   dplus     out D+ drive (registered)
//   dminus    out D- drive (registered)
//   busy      out high from tx_start acceptance until the EOP completes
//   done      out 1-cycle pulse in the last clock of the final EOP J
// -----------------------------------------------------------------------------
module usb_tx_nrzi_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_start,
    input  logic d_bit,
    input  logic pause,
    input  logic eop_req,
    output logic shift_en,
    output logic bit_tick,
    output logic dplus,
    output logic dminus,
    output logic busy,
    output logic done
);

    tx_enc_state_t state;
    line_state_t   line_q;

    logic tick;
    logic start_acc;
    logic timer_en;

    assign start_acc = (state == ST_IDLE) && tx_start;
    assign timer_en  = (state != ST_IDLE);

    usb_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_acc),
        .enable (timer_en),
        .tick   (tick)
    );

    // Strobes are combinational so upstream sees them in the tick cycle
    // itself and can present the next bit before the following boundary.
    assign bit_tick = tick;
    assign shift_en = tick && (state == ST_DATA) && !pause && !eop_req;
    assign done     = tick && (state == ST_EOP_J);
    assign busy     = (state != ST_IDLE);

    // Line drive only moves on the edge that closes a tick cycle, so every
    // symbol is held for exactly CLKS_PER_BIT clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            line_q <= J;
            dplus  <= 1'b1;
            dminus <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (pause) begin
                            // Stuffed 0 wins over eop_req so it is never lost.
                            line_q            <= nrzi_next(line_q, 1'b0);
                            {dplus, dminus}   <= line_encode(nrzi_next(line_q, 1'b0));
                        end else if (eop_req) begin
                            line_q            <= SE0;
                            {dplus, dminus}   <= LINE_SE0;
                            state             <= ST_EOP_SE0_A;
                        end else begin
                            line_q            <= nrzi_next(line_q, d_bit);
                            {dplus, dminus}   <= line_encode(nrzi_next(line_q, d_bit));
                        end
                    end
                end

                ST_EOP_SE0_A: begin
                    if (tick) begin
                        state <= ST_EOP_SE0_B;
                    end
                end

                ST_EOP_SE0_B: begin
                    if (tick) begin
                        line_q          <= J;
                        {dplus, dminus} <= LINE_J;
                        state           <= ST_EOP_J;
                    end
                end

                ST_EOP_J: begin
                    if (tick) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    line_q          <= J;
                    {dplus, dminus} <= LINE_J;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_nrzi_encoder.sv
module tb_usb_tx_nrzi_encoder;

    localparam int CPB = 4;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic clk;
    logic rst;
    logic tx_start;
    logic d_bit;
    logic pause;
    logic eop_req;
    logic shift_en;
    logic bit_tick;
    logic dplus;
    logic dminus;
    logic busy;
    logic done;

    usb_tx_nrzi_encoder #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .d_bit    (d_bit),
        .pause    (pause),
        .eop_req  (eop_req),
        .shift_en (shift_en),
        .bit_tick (bit_tick),
        .dplus    (dplus),
        .dminus   (dminus),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_tick_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       d;
        logic       p;
        logic       e;
        logic [1:0] exp_line;
        logic       exp_shift;
    } vec_t;

    vec_t vecs[22];
    logic [1:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line sanity monitor: never (1,1); no change except right after a tick or reset.
    logic [1:0] prev_line = LJ;
    logic       prev_tick = 1'b0;
    time        last_rst_t = 0;

    always @(posedge rst) last_rst_t = $time;

    always @(negedge clk) begin
        if (dplus && dminus) begin
            checks++;
            failures++;
            $display("FAIL line_11: got %b%b expected never 11 (t=%0t)", dplus, dminus, $time);
        end
        if (({dplus, dminus} != prev_line) && !prev_tick && (($time - last_rst_t) > 10)) begin
            checks++;
            failures++;
            $display("FAIL line_hold: got %b expected %b (t=%0t)", {dplus, dminus}, prev_line, $time);
        end
        prev_line = {dplus, dminus};
        prev_tick = bit_tick;
    end

    // Drive one bit slot, wait for its tick, check strobes, then check the line.
    task automatic apply(input int i);
        bit found;
        logic [1:0] exp;
        @(negedge clk);
        d_bit   = vecs[i].d;
        pause   = vecs[i].p;
        eop_req = vecs[i].e;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bit_tick) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("tick_seen[%0d]", i), 32'(found), 32'd1);
        if (found) begin
            check($sformatf("shift_en[%0d]", i), 32'(shift_en), 32'(vecs[i].exp_shift));
            if (last_tick_cyc >= 0)
                check($sformatf("tick_spacing[%0d]", i), 32'(cyc - last_tick_cyc), 32'(CPB));
            last_tick_cyc = cyc;
            sb_q.push_back(vecs[i].exp_line);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check($sformatf("sb_empty[%0d]", i), 32'd0, 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check($sformatf("line[%0d]", i), 32'({dplus, dminus}), 32'(exp));
            end
        end
    endtask

    task automatic start_packet();
        @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("line_j_after_start", 32'({dplus, dminus}), 32'(LJ));
        last_tick_cyc = -1;
    endtask

    // Called one cycle into SE0; a tx_start pulse is slipped in to prove it is ignored.
    task automatic check_eop(input string tag);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) tx_start = 1'b1;
            if (i == 3) tx_start = 1'b0;
            check($sformatf("%s_se0_%0d", tag, i), 32'({dplus, dminus}), 32'(LSE0));
            check($sformatf("%s_se0_done_%0d", tag, i), 32'(done), 32'd0);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("%s_j_%0d", tag, i), 32'({dplus, dminus}), 32'(LJ));
            check($sformatf("%s_j_done_%0d", tag, i), 32'(done), 32'(i == 4));
            check($sformatf("%s_j_busy_%0d", tag, i), 32'(busy), 32'd1);
        end
        @(negedge clk);
        check($sformatf("%s_busy_low", tag), 32'(busy), 32'd0);
        check($sformatf("%s_done_low", tag), 32'(done), 32'd0);
        check($sformatf("%s_idle_j", tag), 32'({dplus, dminus}), 32'(LJ));
        eop_req = 1'b0;
        pause   = 1'b0;
    endtask

    initial begin
        // d, p, e, expected line after the tick, expected shift_en on the tick
        vecs[0]  = '{1'b0, 1'b0, 1'b0, LK,   1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, LJ,   1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, LK,   1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, LJ,   1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, LK,   1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, LJ,   1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, LK,   1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, LK,   1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, LJ,   1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, LJ,   1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, LK,   1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, LJ,   1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, LSE0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, LJ,   1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, LK,   1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b1, LSE0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, LK,   1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, LJ,   1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, LSE0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, LK,   1'b1};
        vecs[20] = '{1'b1, 1'b0, 1'b0, LK,   1'b1};
        vecs[21] = '{1'b0, 1'b0, 1'b1, LSE0, 1'b0};

        rst = 1'b0; tx_start = 1'b0; d_bit = 1'b0; pause = 1'b0; eop_req = 1'b0;
        last_tick_cyc = -1;

        // Reset asserted between edges takes effect immediately.
        #3 rst = 1'b1;
        #1;
        check("rst_dplus",  32'(dplus),  32'd1);
        check("rst_dminus", 32'(dminus), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        @(negedge clk);
        check("rst_shift_en", 32'(shift_en), 32'd0);
        check("rst_bit_tick", 32'(bit_tick), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Packet 1: SYNC, stuffed bit, tx_start during DATA, pause+eop, EOP.
        start_packet();
        for (int i = 0; i <= 9; i++) apply(i);
        @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_mid_data", 32'(busy), 32'd1);
        for (int i = 10; i <= 12; i++) apply(i);
        check_eop("p1");

        // Packet 2: plain EOP request.
        start_packet();
        for (int i = 13; i <= 15; i++) apply(i);
        check_eop("p2");

        // Packet 3: reset while in the second SE0 bit.
        start_packet();
        for (int i = 16; i <= 18; i++) apply(i);
        repeat (6) @(negedge clk);
        check("p3_se0_before_rst", 32'({dplus, dminus}), 32'(LSE0));
        #2 rst = 1'b1;
        #1;
        check("p3_rst_line", 32'({dplus, dminus}), 32'(LJ));
        check("p3_rst_busy", 32'(busy), 32'd0);
        check("p3_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        eop_req = 1'b0;

        // Packet 4: normal operation after the aborted packet.
        start_packet();
        for (int i = 19; i <= 21; i++) apply(i);
        check_eop("p4");

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
